// File: rtl/fb_pkg.sv
// Frame-buffer constants and requester indices shared by the drawing engine,
// EPP front-end, VGA prefetcher and the port arbiter.
package fb_pkg;
  localparam int FB_WIDTH  = 320;
  localparam int FB_HEIGHT = 200;
  localparam int FB_WORDS  = 8000;
  localparam int FB_ADDR_W = 13;

  localparam int REQ_SCAN = 0;
  localparam int REQ_HOST = 1;
  localparam int REQ_ENG  = 2;

  typedef enum logic {
    LK_IDLE = 1'b0,
    LK_HELD = 1'b1
  } lock_st_e;

  // Index of the set bit in a one-hot requester vector (0 when empty).
  function automatic logic [1:0] fb_idx_of(input logic [2:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    if (oh[REQ_ENG]) begin
      idx = 2'd2;
    end else if (oh[REQ_HOST]) begin
      idx = 2'd1;
    end
    return idx;
  endfunction
endpackage

// File: rtl/fb_port_arbiter_if.sv
// Requester and RAM-side signals of the frame-buffer port arbiter.
interface fb_port_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
);
  import fb_pkg::*;

  // Handshake: requester i's transaction is consumed in the cycle where
  // req[i] && gnt[i]; req/we/lock/addr/wdata must be held until then.
  // gnt never rises without req. Reads complete with a one-cycle rvalid[i].
  logic [2:0]          req;
  logic [2:0]          we;
  logic [2:0]          lock;
  logic [3*ADDR_W-1:0] addr;
  logic [3*DATA_W-1:0] wdata;
  logic [2:0]          gnt;
  logic [2:0]          rvalid;
  logic [DATA_W-1:0]   rdata;
  logic [2:0]          err;
  logic                mem_en;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;
  lock_st_e            lock_st;

  modport slave (
    input  req, we, lock, addr, wdata, mem_rdata,
    output gnt, rvalid, rdata, err, mem_en, mem_we, mem_addr, mem_wdata, lock_st
  );

  modport master (
    output req, we, lock, addr, wdata, mem_rdata,
    input  gnt, rvalid, rdata, err, mem_en, mem_we, mem_addr, mem_wdata, lock_st
  );
endinterface

// File: rtl/fb_rr_pick.sv
// Masked 2-way round-robin picker between host (bit0) and eng (bit1);
// the pointer moves to the other side after whichever one is granted.
module fb_rr_pick (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] taken,
  output logic [1:0] pick
);
  logic ptr_q, ptr_d;

  always_comb begin
    pick  = 2'b00;
    ptr_d = ptr_q;
    if (!ptr_q) begin
      if (req[0])      pick = 2'b01;
      else if (req[1]) pick = 2'b10;
    end else begin
      if (req[1])      pick = 2'b10;
      else if (req[0]) pick = 2'b01;
    end
    if (taken[0])      ptr_d = 1'b1;
    else if (taken[1]) ptr_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end
endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: scan priority with starvation guard,
// host/eng round-robin, owner lock for atomic read-modify-write pairs.
module fb_port_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W   = FB_ADDR_W,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = FB_WORDS,
  parameter int MAX_HOLD = 4,
  parameter int LOCK_MAX = 4
) (
  input logic              uclk,
  input logic              rst_n,
  fb_port_arbiter_if.slave bus
);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam int LOCK_W = $clog2(LOCK_MAX + 1);
  localparam logic [HOLD_W-1:0] HOLD_LIM  = HOLD_W'(MAX_HOLD);
  localparam logic [LOCK_W-1:0] LOCK_LIM  = LOCK_W'(LOCK_MAX);
  localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W+1)'(DEPTH);

  lock_st_e            lock_st_q, lock_st_d;
  logic [1:0]          owner_q, owner_d;
  logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [2:0]          err_q, err_d;
  logic [2:0]          rd_tag_q, rd_tag_d;
  logic [2:0]          rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [2:0]          owner_oh, elig, gnt_c;
  logic [1:0]          rr_pick;
  logic                blocking, force_rel, scan_mask, host_eng_req;
  logic                acc, acc_we, acc_lock, in_range;
  logic [1:0]          acc_idx;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   acc_wdata;

  fb_rr_pick u_rr (
    .clk   (uclk),
    .rst_n (rst_n),
    .req   (elig[REQ_ENG:REQ_HOST]),
    .taken (gnt_c[REQ_ENG:REQ_HOST]),
    .pick  (rr_pick)
  );

  // A forced release arbitrates normally in the same cycle but skips the old owner.
  always_comb begin
    owner_oh     = 3'b001 << owner_q;
    blocking     = (lock_st_q == LK_HELD) && (lock_cnt_q < LOCK_LIM) && |(bus.req & owner_oh);
    force_rel    = (lock_st_q == LK_HELD) && (lock_cnt_q >= LOCK_LIM);
    elig         = force_rel ? (bus.req & ~owner_oh) : bus.req;
    scan_mask    = (hold_cnt_q >= HOLD_LIM);
    host_eng_req = bus.req[REQ_HOST] | bus.req[REQ_ENG];
    gnt_c        = 3'b000;
    if (blocking)                            gnt_c = owner_oh;
    else if (elig[REQ_SCAN] && !scan_mask)   gnt_c = 3'b001;
    else                                     gnt_c = {rr_pick, 1'b0};
  end

  always_comb begin
    acc       = |gnt_c;
    acc_idx   = fb_idx_of(gnt_c);
    acc_addr  = '0;
    acc_wdata = '0;
    acc_we    = 1'b0;
    acc_lock  = 1'b0;
    case (acc_idx)
      2'd0: begin
        acc_addr  = bus.addr[REQ_SCAN*ADDR_W +: ADDR_W];
        acc_wdata = bus.wdata[REQ_SCAN*DATA_W +: DATA_W];
        acc_we    = bus.we[REQ_SCAN];
        acc_lock  = bus.lock[REQ_SCAN];
      end
      2'd1: begin
        acc_addr  = bus.addr[REQ_HOST*ADDR_W +: ADDR_W];
        acc_wdata = bus.wdata[REQ_HOST*DATA_W +: DATA_W];
        acc_we    = bus.we[REQ_HOST];
        acc_lock  = bus.lock[REQ_HOST];
      end
      2'd2: begin
        acc_addr  = bus.addr[REQ_ENG*ADDR_W +: ADDR_W];
        acc_wdata = bus.wdata[REQ_ENG*DATA_W +: DATA_W];
        acc_we    = bus.we[REQ_ENG];
        acc_lock  = bus.lock[REQ_ENG];
      end
      default: ;
    endcase
    in_range = ({1'b0, acc_addr} < DEPTH_LIM);
  end

  always_comb begin
    mem_en_d    = acc && in_range;
    mem_we_d    = mem_en_d && acc_we;
    mem_addr_d  = mem_en_d ? acc_addr : '0;
    mem_wdata_d = mem_we_d ? acc_wdata : '0;
    err_d       = (acc && !in_range) ? gnt_c : 3'b000;
    rd_tag_d    = (mem_en_d && !acc_we) ? gnt_c : 3'b000;
    rvalid_d    = rd_tag_q;
    rdata_d     = (|rvalid_q) ? bus.mem_rdata : rdata_q;

    hold_cnt_d = hold_cnt_q;
    if (!blocking) begin
      if (gnt_c[REQ_SCAN] && host_eng_req) begin
        hold_cnt_d = (hold_cnt_q < HOLD_LIM) ? hold_cnt_q + HOLD_W'(1) : hold_cnt_q;
      end else if (scan_mask || gnt_c[REQ_HOST] || gnt_c[REQ_ENG] || !host_eng_req) begin
        hold_cnt_d = '0;
      end
    end

    lock_st_d  = lock_st_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    if (blocking) begin
      if (acc_lock) begin
        lock_cnt_d = (lock_cnt_q < LOCK_LIM) ? lock_cnt_q + LOCK_W'(1) : lock_cnt_q;
      end else begin
        lock_st_d  = LK_IDLE;
        lock_cnt_d = '0;
      end
    end else if (acc && acc_lock) begin
      lock_st_d  = LK_HELD;
      owner_d    = acc_idx;
      lock_cnt_d = '0;
    end else begin
      lock_st_d  = LK_IDLE;
      lock_cnt_d = '0;
    end
  end

  always_ff @(posedge uclk or negedge rst_n) begin
    if (!rst_n) begin
      lock_st_q   <= LK_IDLE;
      owner_q     <= 2'd0;
      lock_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 3'b000;
      rd_tag_q    <= 3'b000;
      rvalid_q    <= 3'b000;
      rdata_q     <= '0;
    end else begin
      lock_st_q   <= lock_st_d;
      owner_q     <= owner_d;
      lock_cnt_q  <= lock_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
      rd_tag_q    <= rd_tag_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
    end
  end

  // gnt is combinational, so it is forced low while reset is asserted.
  assign bus.gnt       = rst_n ? gnt_c : 3'b000;
  assign bus.rvalid    = rvalid_q;
  assign bus.rdata     = (|rvalid_q) ? bus.mem_rdata : rdata_q;
  assign bus.err       = err_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.lock_st   = lock_st_q;
endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: RAM model, read-data scoreboard and directed
// grant-sequence scenarios.
module tb_fb_port_arbiter;
  import fb_pkg::*;

  localparam int AW    = 13;
  localparam int DW    = 8;
  localparam int DEPTH = 8000;

  logic uclk  = 1'b0;
  logic rst_n = 1'b0;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [AW-1:0] a [3];
  logic [DW-1:0] d [3];
  logic [DW-1:0] ram     [0:8191];
  logic [DW-1:0] ref_mem [0:8191];
  logic [10:0]   exp_q [$];
  int            cnt_h, cnt_e;
  logic [2:0]    exp_g;

  fb_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  fb_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .MAX_HOLD(4), .LOCK_MAX(4)
  ) dut (
    .uclk  (uclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset
  always #5 uclk = ~uclk;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  assign bus.addr  = {a[2], a[1], a[0]};
  assign bus.wdata = {d[2], d[1], d[0]};

  // ---------------- RAM model: data valid the cycle after a read strobe
  always @(posedge uclk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= ram[bus.mem_addr];
    end
  end

  // ---------------- checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard: push on accepted reads, pop on rvalid
  always @(negedge uclk) begin
    if (rst_n) begin
      if (bus.rvalid != 3'b000) begin
        if (exp_q.size() == 0) begin
          check("rv_unexpected", 32'(bus.rvalid), 32'(0));
        end else begin
          check("rv_owner", 32'(bus.rvalid), 32'(exp_q[0][10:8]));
          check("rdata", 32'(bus.rdata), 32'(exp_q[0][7:0]));
          void'(exp_q.pop_front());
        end
      end
      if (bus.gnt != 3'b000) begin
        check("gnt_legal", 32'(((bus.gnt & ~bus.req) == 3'b000) && $onehot(bus.gnt)), 32'(1));
        for (int i = 0; i < 3; i++) begin
          if (bus.gnt[i] && (32'(a[i]) < DEPTH)) begin
            if (bus.we[i]) ref_mem[a[i]] <= d[i];
            else           exp_q.push_back({3'(1 << i), ref_mem[a[i]]});
          end
        end
      end
    end
  end

  // ---------------- driver tasks
  task automatic next_drive();
    @(posedge uclk);
    #1;
  endtask

  task automatic sample();
    @(negedge uclk);
  endtask

  task automatic set_req(input logic [2:0] r, input logic [2:0] w, input logic [2:0] l);
    bus.req  = r;
    bus.we   = w;
    bus.lock = l;
  endtask

  task automatic rand_bus();
    for (int i = 0; i < 3; i++) begin
      a[i] = AW'($urandom_range(0, DEPTH - 1));
      d[i] = DW'($urandom_range(0, 255));
    end
    bus.we = 3'($urandom_range(0, 7));
  endtask

  task automatic check_quiet(input string tag);
    check(tag, 32'({bus.gnt, bus.rvalid, bus.err, bus.mem_en, bus.mem_we}), 32'(0));
    check(tag, 32'({bus.mem_addr, bus.mem_wdata, bus.rdata}), 32'(0));
  endtask

  task automatic do_reset();
    next_drive();
    rst_n = 1'b0;
    set_req(3'b000, 3'b000, 3'b000);
    exp_q.delete();
    sample();
    check_quiet("reset_outputs");
    next_drive();
    next_drive();
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    next_drive();
    set_req(3'b000, 3'b000, 3'b000);
    for (int k = 0; k < n; k++) next_drive();
  endtask

  // ---------------- stimulus
  initial begin
    for (int i = 0; i < 8192; i++) begin
      ram[i]     = DW'(i) ^ 8'h5A;
      ref_mem[i] = DW'(i) ^ 8'h5A;
    end
    ram[5]     = 8'hA5;
    ref_mem[5] = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      a[i] = '0;
      d[i] = '0;
    end
    set_req(3'b000, 3'b000, 3'b000);
    bus.mem_rdata = '0;

    do_reset();

    // single host read of word 5
    next_drive(); set_req(3'b010, 3'b000, 3'b000); a[1] = 13'd5;
    sample();     check("rd_gnt", 32'(bus.gnt), 32'(3'b010));
    next_drive(); set_req(3'b000, 3'b000, 3'b000);
    sample();     check("rd_mem_en", 32'({bus.mem_en, bus.mem_we}), 32'(2'b10));
                  check("rd_mem_addr", 32'(bus.mem_addr), 32'(5));
    next_drive();
    sample();     check("rd_rvalid", 32'(bus.rvalid), 32'(3'b010));
                  check("rd_rdata", 32'(bus.rdata), 32'(8'hA5));
    next_drive();
    sample();     check("rd_hold", 32'({bus.rvalid, bus.rdata}), 32'({3'b000, 8'hA5}));

    // host then eng write/read of the same word
    next_drive(); set_req(3'b010, 3'b010, 3'b000); a[1] = 13'd33; d[1] = 8'h3C;
    sample();     check("wr_gnt", 32'(bus.gnt), 32'(3'b010));
    next_drive(); set_req(3'b100, 3'b000, 3'b000); a[2] = 13'd33;
    sample();     check("wr_mem", 32'({bus.mem_en, bus.mem_we, bus.mem_wdata}), 32'({2'b11, 8'h3C}));
                  check("rw_gnt", 32'(bus.gnt), 32'(3'b100));
    next_drive(); set_req(3'b000, 3'b000, 3'b000);
    next_drive();
    sample();     check("rw_rdata", 32'({bus.rvalid, bus.rdata}), 32'({3'b100, 8'h3C}));
    idle(2);

    // host/eng round-robin, scan idle
    do_reset();
    cnt_h = 0;
    cnt_e = 0;
    for (int k = 0; k < 8; k++) begin
      next_drive(); set_req(3'b110, 3'b000, 3'b000); rand_bus();
      sample();
      exp_g = (k % 2 == 0) ? 3'b010 : 3'b100;
      check("rr_alt", 32'(bus.gnt), 32'(exp_g));
      cnt_h += int'(bus.gnt[1]);
      cnt_e += int'(bus.gnt[2]);
    end
    check("rr_host_cnt", 32'(cnt_h), 32'(4));
    check("rr_eng_cnt", 32'(cnt_e), 32'(4));
    idle(3);

    // all three requesting: scan x4, host, scan x4, eng, ...
    do_reset();
    for (int k = 0; k < 20; k++) begin
      next_drive(); set_req(3'b111, 3'b000, 3'b000); rand_bus();
      sample();
      if (k % 5 != 4)              exp_g = 3'b001;
      else if ((k / 5) % 2 == 0)   exp_g = 3'b010;
      else                         exp_g = 3'b100;
      check("hold_pattern", 32'(bus.gnt), 32'(exp_g));
    end
    idle(3);

    // eng locked read-modify-write at word 10 while scan and host wait
    do_reset();
    next_drive(); set_req(3'b100, 3'b000, 3'b100); a[2] = 13'd10;
    sample();     check("lk_first", 32'(bus.gnt), 32'(3'b100));
    next_drive(); set_req(3'b111, 3'b100, 3'b000); d[2] = 8'hFF; a[0] = 13'd10; a[1] = 13'd20;
    sample();     check("lk_second", 32'(bus.gnt), 32'(3'b100));
                  check("lk_state", 32'(bus.lock_st), 32'(LK_HELD));
    next_drive(); set_req(3'b011, 3'b000, 3'b000);
    sample();     check("lk_after", 32'(bus.gnt), 32'(3'b001));
    next_drive(); set_req(3'b000, 3'b000, 3'b000);
    next_drive();
    sample();     check("lk_new_data", 32'({bus.rvalid, bus.rdata}), 32'({3'b001, 8'hFF}));
    idle(2);

    // forced release after LOCK_MAX blocking cycles excludes the owner once
    do_reset();
    for (int k = 0; k < 8; k++) begin
      next_drive(); set_req(3'b100, 3'b000, 3'b100); a[2] = AW'(100 + k);
      sample();
      exp_g = (k == 5) ? 3'b000 : 3'b100;
      check("lk_force", 32'(bus.gnt), 32'(exp_g));
    end
    idle(3);

    // owner dropping req releases at once; host granted that cycle
    do_reset();
    next_drive(); set_req(3'b100, 3'b000, 3'b100); a[2] = 13'd7;
    sample();     check("lk_drop_first", 32'(bus.gnt), 32'(3'b100));
    next_drive(); set_req(3'b010, 3'b000, 3'b000); a[1] = 13'd8;
    sample();     check("lk_drop_host", 32'(bus.gnt), 32'(3'b010));
    idle(3);

    // out-of-range and boundary addresses
    do_reset();
    next_drive(); set_req(3'b010, 3'b000, 3'b000); a[1] = 13'd8000;
    sample();     check("oor_gnt", 32'(bus.gnt), 32'(3'b010));
    next_drive(); set_req(3'b100, 3'b000, 3'b000); a[2] = 13'd7999;
    sample();     check("oor_err", 32'(bus.err), 32'(3'b010));
                  check("oor_mem_en", 32'(bus.mem_en), 32'(0));
                  check("edge_gnt", 32'(bus.gnt), 32'(3'b100));
    next_drive(); set_req(3'b100, 3'b100, 3'b000); a[2] = 13'd8191; d[2] = 8'h11;
    sample();     check("oor_no_rv", 32'(bus.rvalid), 32'(0));
                  check("edge_mem", 32'({bus.mem_en, bus.err, bus.mem_addr}), 32'({1'b1, 3'b000, 13'd7999}));
    next_drive(); set_req(3'b000, 3'b000, 3'b000);
    sample();     check("oor_wr_err", 32'({bus.err, bus.mem_en}), 32'({3'b100, 1'b0}));
    idle(3);

    // reset one cycle after a read acceptance drops the read
    do_reset();
    next_drive(); set_req(3'b010, 3'b000, 3'b000); a[1] = 13'd5;
    sample();     check("rst_rd_gnt", 32'(bus.gnt), 32'(3'b010));
    next_drive(); rst_n = 1'b0; set_req(3'b110, 3'b000, 3'b000); exp_q.delete();
    sample();     check_quiet("rst_mid");
    next_drive(); rst_n = 1'b1; set_req(3'b000, 3'b000, 3'b000);
    for (int k = 0; k < 3; k++) begin
      sample();   check("rst_no_rv", 32'(bus.rvalid), 32'(0));
      next_drive();
    end
    set_req(3'b110, 3'b000, 3'b000); a[1] = 13'd1; a[2] = 13'd2;
    sample();     check("rst_tie_host", 32'(bus.gnt), 32'(3'b010));
    idle(4);

    check("drain_empty", 32'(exp_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
